// File: rtl/lamp_bus_pkg.sv
// Shared types, default phase timings and mask helper for the lamp-board bus master.
package lamp_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN,
    ST_NEXT,
    ST_DONE
  } lamp_bus_state_t;

  localparam int LAMP_SETUP_CYC  = 88;
  localparam int LAMP_STROBE_CYC = 44;
  localparam int LAMP_HOLD_CYC   = 44;
  localparam int LAMP_TURN_CYC   = 22;
  localparam int LAMP_MAX_CARDS  = 32;

  // Lowest set bit strictly above idx, or -1 when none; idx = -1 yields the lowest set bit.
  function automatic int next_set_bit(input logic [LAMP_MAX_CARDS-1:0] mask, input int idx);
    int res;
    res = -1;
    for (int i = LAMP_MAX_CARDS - 1; i >= 0; i--) begin
      if (mask[i] && (i > idx)) res = i;
    end
    return res;
  endfunction

endpackage

// File: rtl/lamp_bus_phase_timer.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a phase.
module lamp_bus_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lamp_bus_master.sv
// Lamp-board bus sequencer: walks the enabled cards of one command through
// select/setup/strobe/hold/turn phases with fully registered pin outputs.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// SELECT | board ID/address (and write data) driven this cycle
// SETUP  | address settles before the strobe
// STROBE | RdP/WrP low; read data captured on the last edge
// HOLD   | address/ID/data held after strobe release
// TURN   | bus released before the next card
// NEXT   | pick next enabled card or finish
// DONE   | raise rsp_valid, then return to IDLE
module lamp_bus_master
  import lamp_bus_pkg::*;
#(
  parameter int NUM_CARDS  = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int SETUP_CYC  = LAMP_SETUP_CYC,
  parameter int STROBE_CYC = LAMP_STROBE_CYC,
  parameter int HOLD_CYC   = LAMP_HOLD_CYC,
  parameter int TURN_CYC   = LAMP_TURN_CYC
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [NUM_CARDS-1:0]        cmd_card_mask,
  input  logic [NUM_CARDS*DATA_W-1:0] cmd_wdata,
  output logic                        rsp_valid,
  output logic [NUM_CARDS*DATA_W-1:0] rsp_rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [NUM_CARDS-1:0]        bus_bid,
  output logic [DATA_W-1:0]           bus_dout,
  output logic                        bus_doe,
  input  logic [DATA_W-1:0]           bus_din,
  output logic                        bus_rd_n,
  output logic                        bus_wr_n
);

  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HT  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int MAX_CYC = (MAX_SS > MAX_HT) ? MAX_SS : MAX_HT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TURN_CYC < 1 ||
      NUM_CARDS < 1 || NUM_CARDS > LAMP_MAX_CARDS) begin : g_bad_cfg
    $error("lamp_bus_master: phase cycle counts must be >= 1 and NUM_CARDS within 1..32");
  end

  lamp_bus_state_t             state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        write_q, write_d;
  logic [NUM_CARDS-1:0]        mask_q, mask_d;
  logic [NUM_CARDS*DATA_W-1:0] wdata_q, wdata_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        busy_q, busy_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [NUM_CARDS*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]           bus_addr_q, bus_addr_d;
  logic [NUM_CARDS-1:0]        bus_bid_q, bus_bid_d;
  logic [DATA_W-1:0]           bus_dout_q, bus_dout_d;
  logic                        bus_doe_q, bus_doe_d;
  logic                        bus_rd_n_q, bus_rd_n_d;
  logic                        bus_wr_n_q, bus_wr_n_d;

  logic             tmr_load, tmr_zero, go_select;
  logic [CNT_W-1:0] tmr_val;
  int               first_idx, nxt_idx;

  lamp_bus_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_bid_d   = bus_bid_q;
    bus_dout_d  = bus_dout_q;
    bus_doe_d   = bus_doe_q;
    bus_rd_n_d  = bus_rd_n_q;
    bus_wr_n_d  = bus_wr_n_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    go_select   = 1'b0;
    first_idx   = next_set_bit(LAMP_MAX_CARDS'(cmd_card_mask), -1);
    nxt_idx     = next_set_bit(LAMP_MAX_CARDS'(mask_q), int'(idx_q));

    case (state_q)
      ST_IDLE: begin
        // cmd_ready rises one cycle after rsp_valid, so the pulse cycle never accepts.
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          mask_d      = cmd_card_mask;
          wdata_d     = cmd_wdata;
          rsp_rdata_d = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (first_idx < 0) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = IDX_W'(first_idx);
            bus_addr_d = cmd_addr;
            go_select  = 1'b1;
            state_d    = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(SETUP_CYC - 1);
        state_d  = ST_SETUP;
      end
      ST_SETUP: if (tmr_zero) begin
        if (write_q) bus_wr_n_d = 1'b0;
        else         bus_rd_n_d = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(STROBE_CYC - 1);
        state_d  = ST_STROBE;
      end
      ST_STROBE: if (tmr_zero) begin
        bus_wr_n_d = 1'b1;
        bus_rd_n_d = 1'b1;
        if (!write_q) rsp_rdata_d[idx_q*DATA_W +: DATA_W] = bus_din;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(HOLD_CYC - 1);
        state_d  = ST_HOLD;
      end
      ST_HOLD: if (tmr_zero) begin
        bus_doe_d = 1'b0;
        bus_bid_d = '0;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(TURN_CYC - 1);
        state_d   = ST_TURN;
      end
      ST_TURN: if (tmr_zero) state_d = ST_NEXT;
      ST_NEXT: begin
        if (nxt_idx < 0) begin
          state_d = ST_DONE;
        end else begin
          idx_d     = IDX_W'(nxt_idx);
          go_select = 1'b1;
          state_d   = ST_SELECT;
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_select) begin
      bus_bid_d  = NUM_CARDS'(1) << idx_d;
      bus_doe_d  = write_d;
      bus_dout_d = write_d ? wdata_d[idx_d*DATA_W +: DATA_W] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= '0;
      bus_bid_q   <= '0;
      bus_dout_q  <= '0;
      bus_doe_q   <= 1'b0;
      bus_rd_n_q  <= 1'b1;
      bus_wr_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_bid_q   <= bus_bid_d;
      bus_dout_q  <= bus_dout_d;
      bus_doe_q   <= bus_doe_d;
      bus_rd_n_q  <= bus_rd_n_d;
      bus_wr_n_q  <= bus_wr_n_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_bid   = bus_bid_q;
  assign bus_dout  = bus_dout_q;
  assign bus_doe   = bus_doe_q;
  assign bus_rd_n  = bus_rd_n_q;
  assign bus_wr_n  = bus_wr_n_q;

endmodule
